matmul_seq: RTL and testbench
=============================

MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width in bits for A, B and C.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N x N), legal range 2..16.
REQ-003 SHALL have parameter SIGNED, default 0; 1 selects two's-complement elements, 0 selects unsigned.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request to multiply; sampled only while busy=0.
REQ-007 SHALL have port A, input, WIDTH*N*N, row-major; element (r,c) at bits [(r*N+c)*WIDTH +: WIDTH].
REQ-008 SHALL have port B, input, WIDTH*N*N, same packing as A.
REQ-009 SHALL have port C, output, WIDTH*N*N, result C=A*B, same packing.
REQ-010 SHALL have port busy, output, 1, high while computing.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when C is complete.

Function
REQ-012 SHALL implement states IDLE, COMPUTE, DONE.
REQ-013 IDLE or DONE with start=1 at an edge: SHALL capture A and B into internal registers, clear row/k counters and accumulators, go to COMPUTE.
REQ-014 SHALL ignore start and any change on A/B while in COMPUTE.
REQ-015 COMPUTE: each cycle N lanes j SHALL accumulate A[i][k]*B[k][j]; k counts 0..N-1, then i advances, wrapping to 0 after N-1.
REQ-016 At the edge where k=N-1, row i of C SHALL be written from the N accumulators, and the accumulators SHALL clear.
REQ-017 COMPUTE SHALL last exactly N*N cycles; after the last one the state SHALL go to DONE.
REQ-018 busy SHALL be 1 exactly in COMPUTE; done SHALL be 1 exactly in DONE; DONE lasts one cycle.
REQ-019 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL start a new job per REQ-013 (back-to-back).
REQ-020 Latency from start edge to done high SHALL be N*N+1 cycles.
REQ-021 Accumulators SHALL be ACC_W = 2*WIDTH + clog2(N) bits, sign-extended when SIGNED=1; no internal overflow.
REQ-022 C rows SHALL hold their previous values until overwritten; C is valid as a whole only from done onward, until the next row write.

Reset
REQ-023 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, C=0, counters and accumulators 0, regardless of state.
REQ-024 Reset mid-COMPUTE SHALL abort the job with no done pulse; the first start after rst_n=1 SHALL behave as from power-up.

Configuration
REQ-025 Macro MATMUL_SAT_EN defined: row write SHALL saturate ACC to WIDTH bits (unsigned: 0..2^WIDTH-1; signed: -2^(WIDTH-1)..2^(WIDTH-1)-1).
REQ-026 MATMUL_SAT_EN undefined: row write SHALL take the low WIDTH bits of ACC (wrap-around).

Structure
REQ-027 Package matmul_pkg SHALL hold the state enum and the ACC_W width function.
REQ-028 Sub-module matmul_mac_lane (one multiply-accumulate plus clear) SHALL be instantiated N times.

Verification
REQ-029 N=4, A=identity, B elements 1..16 -> C=B; done high exactly 17 cycles after start edge; busy high 16 cycles.
REQ-030 N=4 unsigned, all elements 0xFFFF -> each C element 0x0004 without MATMUL_SAT_EN, 0xFFFF with it.
REQ-031 SIGNED=1, A all 0xFFFF (-1), B all 0x0001 -> each C element 0xFFFC in both builds.
REQ-032 start pulsed at COMPUTE cycle 3 with different A/B -> ignored; result of the first job; a single done pulse.
REQ-033 rst_n low at COMPUTE cycle 5 -> next cycle busy=0, done=0, C=0; restart gives the correct result with 17-cycle latency.
REQ-034 N=2, start held high -> done every 5 cycles, each result correct (back-to-back).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types for the sequential matrix multiplier: FSM states and accumulator width.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Wide enough that N products of two WIDTH-bit elements can never overflow.
    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One column lane of the multiplier: acc += a*b each enabled cycle, with synchronous clear.
module matmul_mac_lane
    import matmul_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = acc_width(16, 4),
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    // Extending to ACC_W first lets one modular multiply serve both signed and unsigned.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{(ACC_W-WIDTH){a[WIDTH-1]}}, a};
            b_ext = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b};
        end else begin
            a_ext = {{(ACC_W-WIDTH){1'b0}}, a};
            b_ext = {{(ACC_W-WIDTH){1'b0}}, b};
        end
        prod = a_ext * b_ext;
        sum  = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier, one row of C per N cycles using N MAC lanes.
// Define MATMUL_SAT_EN to saturate results to WIDTH bits instead of wrapping.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N      = 4,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH*N*N-1:0] A,
    input  logic [WIDTH*N*N-1:0] B,
    output logic [WIDTH*N*N-1:0] C,
    output logic                 busy,
    output logic                 done
);

    localparam int ACC_W = acc_width(WIDTH, N);
    localparam int CW    = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state;
    logic [CW-1:0]        row;
    logic [CW-1:0]        k;
    logic [WIDTH*N*N-1:0] a_reg;
    logic [WIDTH*N*N-1:0] b_reg;
    logic [ACC_W-1:0]     sums [N];
    logic [WIDTH-1:0]     a_elem;
    logic                 accept;
    logic                 computing;
    logic                 row_end;

    assign computing = (state == COMPUTE);
    assign accept    = (state != COMPUTE) && start;
    assign row_end   = computing && (k == LAST);
    assign a_elem    = a_reg[(int'(row) * N + int'(k)) * WIDTH +: WIDTH];

    function automatic logic [WIDTH-1:0] narrow(input logic [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
        if (SIGNED != 0) begin
            if (v[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){v[ACC_W-1]}})
                return v[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else if (|v[ACC_W-1:WIDTH]) begin
            return '1;
        end
`endif
        return v[WIDTH-1:0];
    endfunction

    // Lane j owns column j; every lane sees the same A[row][k] and its own B[k][j].
    for (genvar j = 0; j < N; j++) begin : g_lane
        matmul_mac_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W),
            .SIGNED(SIGNED)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(accept || row_end),
            .en   (computing),
            .a    (a_elem),
            .b    (b_reg[(int'(k) * N + j) * WIDTH +: WIDTH]),
            .sum  (sums[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            C     <= '0;
            row   <= '0;
            k     <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        row   <= '0;
                        k     <= '0;
                        state <= COMPUTE;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (k == LAST) begin
                        k <= '0;
                        // The final product is folded in here via the lanes' combinational sum.
                        for (int j = 0; j < N; j++)
                            C[(int'(row) * N + j) * WIDTH +: WIDTH] <= narrow(sums[j]);
                        if (row == LAST) begin
                            row   <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Randomized self-checking bench for matmul_seq: N=4 unsigned, N=4 signed and N=2 instances.
module tb_matmul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         start4 = 1'b0, starts = 1'b0, start2 = 1'b0;
    logic [255:0] a4 = '0, b4 = '0, as_ = '0, bs = '0;
    logic [63:0]  a2 = '0, b2 = '0;
    logic [255:0] c4, cs;
    logic [63:0]  c2;
    logic         busy4, done4, busys, dones, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_seq #(.WIDTH(16), .N(4), .SIGNED(0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .C(c4), .busy(busy4), .done(done4));

    matmul_seq #(.WIDTH(16), .N(4), .SIGNED(1)) us (
        .clk(clk), .rst_n(rst_n), .start(starts), .A(as_), .B(bs),
        .C(cs), .busy(busys), .done(dones));

    matmul_seq #(.WIDTH(16), .N(2), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2),
        .C(c2), .busy(busy2), .done(done2));

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer matrix product, then saturate or keep the low 16 bits.
    function automatic longint elem(input logic [255:0] m, input int r, input int c, input int n, input bit sgn);
        logic [15:0] e;
        e = m[(r * n + c) * 16 +: 16];
        return sgn ? longint'($signed(e)) : longint'(e);
    endfunction

    function automatic logic [15:0] narrow_ref(input longint s, input bit sgn);
        logic [63:0] t;
`ifdef MATMUL_SAT_EN
        if (sgn) begin
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
        end else if (s > 65535) begin
            s = 65535;
        end
`endif
        t = s;
        return t[15:0];
    endfunction

    function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b, input int n, input bit sgn);
        logic [255:0] res;
        longint s;
        res = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += elem(a, r, k, n, sgn) * elem(b, k, c, n, sgn);
                res[(r * n + c) * 16 +: 16] = narrow_ref(s, sgn);
            end
        return res;
    endfunction

    function automatic logic [255:0] rand_mat();
        logic [255:0] m;
        for (int i = 0; i < 8; i++)
            m[i * 32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic applyStimulus(input int which, input logic [255:0] a, input logic [255:0] b, input logic s);
        case (which)
            0: begin a4 = a; b4 = b; start4 = s; end
            1: begin as_ = a; bs = b; starts = s; end
            default: begin a2 = a[63:0]; b2 = b[63:0]; start2 = s; end
        endcase
    endtask

    task automatic drop_start(input int which);
        case (which)
            0: start4 = 1'b0;
            1: starts = 1'b0;
            default: start2 = 1'b0;
        endcase
    endtask

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy4 : (which == 1) ? busys : busy2;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? done4 : (which == 1) ? dones : done2;
    endfunction

    function automatic logic [255:0] get_c(input int which);
        return (which == 0) ? c4 : (which == 1) ? cs : {192'd0, c2};
    endfunction

    // Latency counts rising edges from the start edge (as 1) through the edge raising done.
    task automatic run_job(input int which, input logic [255:0] a, input logic [255:0] b,
                           output int lat, output int bc, output logic [255:0] c);
        lat = 0;
        bc  = 0;
        applyStimulus(which, a, b, 1'b1);
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            drop_start(which);
            if (get_busy(which)) bc++;
            if (get_done(which)) break;
        end
        c = get_c(which);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [255:0] a, b, c, a1, b1;
        int lat, bc, ndone, prev, t, jobs;

        tick(2);
        checkOutput("reset_busy", {255'd0, busy4}, 256'd0);
        checkOutput("reset_done", {255'd0, done4}, 256'd0);
        checkOutput("reset_c", c4, 256'd0);
        rst_n = 1'b1;
        tick(1);

        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++) begin
                a[(r * 4 + cc) * 16 +: 16] = (r == cc) ? 16'd1 : 16'd0;
                b[(r * 4 + cc) * 16 +: 16] = 16'(r * 4 + cc + 1);
            end
        run_job(0, a, b, lat, bc, c);
        checkOutput("ident_c", c, b);
        checkOutput("ident_latency", 256'(lat), 256'd17);
        checkOutput("ident_busy_cycles", 256'(bc), 256'd16);
        tick(1);
        checkOutput("done_one_cycle", {255'd0, done4}, 256'd0);

        for (int i = 0; i < 4; i++) begin
            a = rand_mat();
            b = rand_mat();
            run_job(0, a, b, lat, bc, c);
            checkOutput("rand_u_c", c, model(a, b, 4, 1'b0));
            checkOutput("rand_u_latency", 256'(lat), 256'd17);
            tick($urandom_range(2, 0));
        end

        run_job(0, '1, '1, lat, bc, c);
`ifdef MATMUL_SAT_EN
        checkOutput("all_ffff", c, {16{16'hFFFF}});
`else
        checkOutput("all_ffff", c, {16{16'h0004}});
`endif

        run_job(1, '1, {16{16'h0001}}, lat, bc, c);
        checkOutput("signed_neg", c, {16{16'hFFFC}});
        for (int i = 0; i < 3; i++) begin
            a = rand_mat();
            b = rand_mat();
            run_job(1, a, b, lat, bc, c);
            checkOutput("rand_s_c", c, model(a, b, 4, 1'b1));
        end

        // A second start during COMPUTE with new operands must be ignored.
        a1 = rand_mat();
        b1 = rand_mat();
        applyStimulus(0, a1, b1, 1'b1);
        tick(1);
        start4 = 1'b0;
        tick(2);
        applyStimulus(0, rand_mat(), rand_mat(), 1'b1);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            start4 = 1'b0;
            if (done4) ndone++;
        end
        checkOutput("ignore_start_c", c4, model(a1, b1, 4, 1'b0));
        checkOutput("ignore_start_dones", 256'(ndone), 256'd1);

        // Reset in the middle of a job aborts it without a done pulse.
        applyStimulus(0, rand_mat(), rand_mat(), 1'b1);
        tick(1);
        start4 = 1'b0;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        checkOutput("midreset_busy", {255'd0, busy4}, 256'd0);
        checkOutput("midreset_done", {255'd0, done4}, 256'd0);
        checkOutput("midreset_c", c4, 256'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done4) ndone++;
        end
        checkOutput("midreset_no_done", 256'(ndone), 256'd0);
        a = rand_mat();
        b = rand_mat();
        run_job(0, a, b, lat, bc, c);
        checkOutput("restart_c", c, model(a, b, 4, 1'b0));
        checkOutput("restart_latency", 256'(lat), 256'd17);

        // N=2 with start held: one result every N*N+1 cycles.
        a = rand_mat();
        b = rand_mat();
        applyStimulus(2, a, b, 1'b1);
        prev = 0;
        t = 0;
        jobs = 0;
        while (jobs < 4 && t < 100) begin
            tick(1);
            t++;
            if (done2) begin
                checkOutput("b2b_c", {192'd0, c2}, model({192'd0, a[63:0]}, {192'd0, b[63:0]}, 2, 1'b0));
                checkOutput("b2b_gap", 256'(t - prev), 256'd5);
                prev = t;
                jobs++;
                a = rand_mat();
                b = rand_mat();
                applyStimulus(2, a, b, jobs < 4);
            end
        end
        checkOutput("b2b_jobs", 256'(jobs), 256'd4);
        start2 = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
